// File: rtl/baud_pkg.sv
// Shared defaults, configuration record and divisor calculator for the fractional baud generator.
package baud_pkg;

  localparam int DEF_DIV_W    = 16;
  localparam int DEF_FRAC_W   = 8;
  localparam int DEF_OVS      = 16;
  localparam int DEF_DIV_INT  = 27;
  localparam int DEF_DIV_FRAC = 32;

  typedef struct packed {
    logic [DEF_DIV_W-1:0]  div_i;
    logic [DEF_FRAC_W-1:0] div_f;
  } baud_cfg_t;

  // Rounded clk_hz / (baud * ovs) in fixed point with DEF_FRAC_W fraction bits.
  function automatic baud_cfg_t calc_div(input longint unsigned clk_hz,
                                         input longint unsigned baud,
                                         input longint unsigned ovs);
    longint unsigned tick_hz;
    longint unsigned scaled;
    baud_cfg_t       cfg;
    tick_hz   = baud * ovs;
    scaled    = ((clk_hz << DEF_FRAC_W) + (tick_hz >> 1)) / tick_hz;
    cfg.div_i = DEF_DIV_W'(scaled >> DEF_FRAC_W);
    cfg.div_f = DEF_FRAC_W'(scaled);
    return cfg;
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Divisor reload handshake between a configuration master and the baud generator.
interface baud_gen_frac_if
  import baud_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FRAC_W = DEF_FRAC_W
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div_i;
  logic [FRAC_W-1:0] cfg_div_f;

  modport master (output cfg_valid, output cfg_div_i, output cfg_div_f, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div_i, input  cfg_div_f, output cfg_ready);

endinterface

// File: rtl/baud_frac_div.sv
// Fractional-N tick divider: down-counter plus dithering accumulator (BAUD_GEN_FRAC_EN).
// Without BAUD_GEN_FRAC_EN the accumulator is absent and every period is exactly div_i cycles.
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int DEF_DIV_I = DEF_DIV_INT,
  parameter int DEF_DIV_F = DEF_DIV_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DIV_W-1:0]  load_div_i,
  input  logic [FRAC_W-1:0] load_div_f,
  input  logic              resync,
  output logic              tick
);

  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV_I = (DEF_DIV_I < 2) ? MIN_DIV : DIV_W'(DEF_DIV_I);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0]  div_i_r;
  logic [FRAC_W-1:0] div_f_r;
  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  clamp_div_s;
  logic              carry_s;

  // A divisor below 2 would hold the tick high continuously.
  assign clamp_div_s = (load_div_i < MIN_DIV) ? MIN_DIV : load_div_i;
  assign tick        = en && !resync && (cnt_r == {DIV_W{1'b0}});

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] frac_acc_r;
  logic [FRAC_W:0]   frac_sum_s;

  assign frac_sum_s = {1'b0, frac_acc_r} + {1'b0, div_f_r};
  assign carry_s    = frac_sum_s[FRAC_W];

  // Fraction accumulator: advances once per tick, cleared by a divisor load.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_acc_r <= {FRAC_W{1'b0}};
    end else if (load) begin
      frac_acc_r <= {FRAC_W{1'b0}};
    end else if (tick) begin
      frac_acc_r <= frac_sum_s[FRAC_W-1:0];
    end else begin
      frac_acc_r <= frac_acc_r;
    end
  end
`else
  logic unused_frac_s;

  assign carry_s       = 1'b0;
  assign unused_frac_s = ^div_f_r;
`endif

  // Active divisor and period counter; a load takes priority over resync and ticking.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_i_r <= RST_DIV_I;
      div_f_r <= FRAC_W'(DEF_DIV_F);
      cnt_r   <= RST_DIV_I - ONE;
    end else if (load) begin
      div_i_r <= clamp_div_s;
      div_f_r <= load_div_f;
      cnt_r   <= clamp_div_s - ONE;
    end else if (en && resync) begin
      cnt_r   <= div_i_r - ONE;
    end else if (tick) begin
      cnt_r   <= div_i_r - ONE + {{(DIV_W-1){1'b0}}, carry_s};
    end else if (en) begin
      cnt_r   <= cnt_r - ONE;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional-N baud generator: oversample, tx bit and rx mid-bit strobes.
// Fractional dithering is built only when BAUD_GEN_FRAC_EN is defined.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int OVS       = DEF_OVS,
  parameter int DEF_DIV_I = DEF_DIV_INT,
  parameter int DEF_DIV_F = DEF_DIV_FRAC
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            en,
  baud_gen_frac_if.slave  cfg,
  input  logic            rx_resync,
  output logic            rxclk_en,
  output logic            txclk_en,
  output logic            rx_sample
);

  localparam int              PH_W    = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0]   tx_ph_r;
  logic [PH_W-1:0]   rx_ph_r;
  logic              cfg_ready_r;
  logic [DIV_W-1:0]  pend_div_i_r;
  logic [FRAC_W-1:0] pend_div_f_r;
  logic              tick_s;
  logic              txclk_en_s;
  logic              load_s;

  // A pending divisor (cfg_ready low) waits for a bit boundary unless the generator is idle.
  assign txclk_en_s    = tick_s && (tx_ph_r == PH_LAST);
  assign load_s        = !cfg_ready_r && (en ? txclk_en_s : 1'b1);
  assign rxclk_en      = tick_s;
  assign txclk_en      = txclk_en_s;
  assign rx_sample     = tick_s && (rx_ph_r == PH_MID);
  assign cfg.cfg_ready = cfg_ready_r;

  baud_frac_div #(
    .DIV_W     (DIV_W),
    .FRAC_W    (FRAC_W),
    .DEF_DIV_I (DEF_DIV_I),
    .DEF_DIV_F (DEF_DIV_F)
  ) u_div (
    .clk        (clk_50m),
    .rst        (rst),
    .en         (en),
    .load       (load_s),
    .load_div_i (pend_div_i_r),
    .load_div_f (pend_div_f_r),
    .resync     (rx_resync),
    .tick       (tick_s)
  );

  // Bit phase counters; OVS is a power of two so the increment wraps by itself.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_ph_r <= {PH_W{1'b0}};
      rx_ph_r <= {PH_W{1'b0}};
    end else if (load_s) begin
      tx_ph_r <= {PH_W{1'b0}};
      rx_ph_r <= {PH_W{1'b0}};
    end else if (en && rx_resync) begin
      tx_ph_r <= tx_ph_r;
      rx_ph_r <= {PH_W{1'b0}};
    end else if (tick_s) begin
      tx_ph_r <= tx_ph_r + PH_ONE;
      rx_ph_r <= rx_ph_r + PH_ONE;
    end else begin
      tx_ph_r <= tx_ph_r;
      rx_ph_r <= rx_ph_r;
    end
  end

  // Reload handshake; while a divisor is pending further offers are ignored.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cfg_ready_r  <= 1'b1;
      pend_div_i_r <= {DIV_W{1'b0}};
      pend_div_f_r <= {FRAC_W{1'b0}};
    end else if (load_s) begin
      cfg_ready_r  <= 1'b1;
    end else if (cfg.cfg_valid && cfg_ready_r) begin
      cfg_ready_r  <= 1'b0;
      pend_div_i_r <= cfg.cfg_div_i;
      pend_div_f_r <= cfg.cfg_div_f;
    end else begin
      cfg_ready_r  <= cfg_ready_r;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus random traffic against a tick-time reference model.
module tb_baud_gen_frac;
  import baud_pkg::*;

`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  localparam int OVS      = DEF_OVS;
  localparam int FRAC_ONE = 1 << DEF_FRAC_W;

  logic clk_50m = 1'b0;
  logic rst, en, rx_resync;
  logic rxclk_en, txclk_en, rx_sample;
  logic obs_rx, obs_tx, obs_rs, obs_rdy;
  int   checks = 0;
  int   errors = 0;

  // Reference model: tick k of a segment falls at enabled cycle seg + k*di - 1 + floor((acc0+(k-1)*df)/2^F).
  int m_di, m_df, m_acc0, m_k, m_seg, m_ecnt = 0;
  int m_txn, m_rxn, m_pi, m_pf;
  bit m_ready;

  baud_gen_frac_if cfg_if ();

  baud_gen_frac dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg_if),
    .rx_resync (rx_resync),
    .rxclk_en  (rxclk_en),
    .txclk_en  (txclk_en),
    .rx_sample (rx_sample)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_di = DEF_DIV_INT; m_df = FRAC_ON ? DEF_DIV_FRAC : 0;
    m_acc0 = 0; m_k = 1; m_seg = m_ecnt; m_txn = 0; m_rxn = 0; m_ready = 1'b1;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model over the edge.
  task automatic step();
    int tgt;
    bit t, tx, rs, apply, acc;
    @(negedge clk_50m);
    tgt = m_seg + m_k * m_di - 1 + (m_acc0 + (m_k - 1) * m_df) / FRAC_ONE;
    t   = en && !rx_resync && (m_ecnt == tgt);
    tx  = t && (m_txn % OVS == OVS - 1);
    rs  = t && (m_rxn % OVS == OVS / 2 - 1);
    obs_rx = rxclk_en; obs_tx = txclk_en; obs_rs = rx_sample; obs_rdy = cfg_if.cfg_ready;
    if (!rst) begin
      check("rxclk_en", 32'(obs_rx), 32'(t));
      check("txclk_en", 32'(obs_tx), 32'(tx));
      check("rx_sample", 32'(obs_rs), 32'(rs));
      check("cfg_ready", 32'(obs_rdy), 32'(m_ready));
    end
    if (rst) begin
      model_reset();
    end else begin
      acc   = cfg_if.cfg_valid && m_ready;
      apply = !m_ready && (en ? tx : 1'b1);
      if (en) m_ecnt++;
      if (apply) begin
        m_di = (m_pi < 2) ? 2 : m_pi; m_df = FRAC_ON ? m_pf : 0;
        m_acc0 = 0; m_k = 1; m_seg = m_ecnt; m_txn = 0; m_rxn = 0; m_ready = 1'b1;
      end else if (en && rx_resync) begin
        m_acc0 = (m_acc0 + (m_k - 1) * m_df) % FRAC_ONE;
        m_k = 1; m_seg = m_ecnt; m_rxn = 0;
      end else if (t) begin
        m_k++; m_txn++; m_rxn++;
      end
      if (acc) begin
        m_pi = int'(cfg_if.cfg_div_i); m_pf = int'(cfg_if.cfg_div_f); m_ready = 1'b0;
      end
    end
    @(posedge clk_50m);
    #1;
  endtask

  // Step until the selected strobe is seen (0 rx, 1 tx, 2 sample); n is the step count.
  task automatic wait_ev(input int sel, output int n);
    bit seen;
    seen = 1'b0; n = 0;
    while (!seen && n < 3000) begin
      step(); n++;
      case (sel)
        0:       seen = (obs_rx === 1'b1);
        1:       seen = (obs_tx === 1'b1);
        default: seen = (obs_rs === 1'b1);
      endcase
    end
    check("wait_timeout", 32'(seen), 32'd1);
  endtask

  task automatic send_cfg(input int di, input int df);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_i = 16'(di); cfg_if.cfg_div_f = 8'(df);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    int n, cnt, first_tx, strobes, dbl;
    bit prev;
    rst = 1'b1; en = 1'b1; rx_resync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div_i = 16'd0; cfg_if.cfg_div_f = 8'd0;
    step(); step();
    rst = 1'b0;

    // Defaults after reset release.
    cnt = 0; first_tx = 0;
    for (int c = 1; c <= 461; c++) begin
      step();
      if (obs_rx === 1'b1) cnt++;
      if (obs_tx === 1'b1 && first_tx == 0) first_tx = c;
      if (c == 434) check("t1_rx_in_434", 32'(cnt), 32'd16);
    end
    check("t1_rx_in_461", 32'(cnt), 32'd17);
    check("t1_first_tx", 32'(first_tx), FRAC_ON ? 32'd433 : 32'd432);

    // Divisor 4 + 1/2.
    send_cfg(4, 8'h80);
    wait_ev(1, n);
    wait_ev(0, n); check("t2_p1", 32'(n), 32'd4);
    wait_ev(0, n); check("t2_p2", 32'(n), 32'd4);
    wait_ev(0, n); check("t2_p3", 32'(n), FRAC_ON ? 32'd5 : 32'd4);
    wait_ev(1, n);
    wait_ev(1, n); check("t2_tx_period", 32'(n), FRAC_ON ? 32'd72 : 32'd64);

    // Reload mid-bit; the second offer must be ignored.
    for (int i = 0; i < 5; i++) step();
    send_cfg(6, 0);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_i = 16'd9; cfg_if.cfg_div_f = 8'h40;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t3_ready_low", 32'(obs_rdy), 32'd0);
    wait_ev(1, n); check("t3_old_rate_tx", 32'(n), FRAC_ON ? 32'd65 : 32'd57);
    check("t3_ready_at_apply", 32'(obs_rdy), 32'd0);
    step(); check("t3_ready_after", 32'(obs_rdy), 32'd1);
    wait_ev(0, n); check("t3_new_first", 32'(n), 32'd5);
    wait_ev(0, n); check("t3_new_period", 32'(n), 32'd6);

    // rx resync, then resync colliding with a tick.
    step(); step();
    rx_resync = 1'b1; step(); rx_resync = 1'b0;
    wait_ev(2, n); check("t4_resync_to_sample", 32'(n), 32'd48);
    for (int i = 0; i < 5; i++) step();
    rx_resync = 1'b1; step(); rx_resync = 1'b0;
    check("t4_coinc_rx", 32'(obs_rx), 32'd0);
    check("t4_coinc_rs", 32'(obs_rs), 32'd0);
    wait_ev(0, n); check("t4_after_coinc", 32'(n), 32'd6);

    // Divisors below 2 clamp to 2.
    send_cfg(1, 0);
    wait_ev(1, n);
    wait_ev(0, n); check("t5_div1_p1", 32'(n), 32'd2);
    wait_ev(0, n); check("t5_div1_p2", 32'(n), 32'd2);
    dbl = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev && obs_rx === 1'b1) dbl++;
      prev = (obs_rx === 1'b1);
    end
    check("t5_never_held", 32'(dbl), 32'd0);
    send_cfg(0, 0);
    wait_ev(1, n);
    wait_ev(0, n); check("t5_div0_p", 32'(n), 32'd2);

    // Idle reload, freeze and resume, reset with a pending divisor.
    en = 1'b0;
    send_cfg(5, 0);
    step(); check("t6_ready_apply_en0", 32'(obs_rdy), 32'd0);
    step(); check("t6_ready_en0", 32'(obs_rdy), 32'd1);
    en = 1'b1;
    wait_ev(0, n); check("t6_first_after_idle", 32'(n), 32'd5);
    step(); step();
    en = 1'b0; strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_rx !== 1'b0 || obs_tx !== 1'b0 || obs_rs !== 1'b0) strobes++;
    end
    check("t6_no_strobes", 32'(strobes), 32'd0);
    en = 1'b1;
    wait_ev(0, n); check("t6_resume", 32'(n), 32'd3);
    send_cfg(7, 0);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    step(); check("t6_ready_after_rst", 32'(obs_rdy), 32'd1);
    wait_ev(1, n); check("t6_tx_after_rst", 32'(n), FRAC_ON ? 32'd432 : 32'd431);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      en               = ($urandom_range(0, 19) != 0);
      rx_resync        = ($urandom_range(0, 79) == 0);
      cfg_if.cfg_valid = ($urandom_range(0, 29) == 0);
      cfg_if.cfg_div_i = 16'($urandom_range(0, 9));
      cfg_if.cfg_div_f = 8'($urandom_range(0, 255));
      rst              = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0; en = 1'b1; rx_resync = 1'b0; cfg_if.cfg_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
